fsmv_driver: RTL and testbench

Host-side sequencer driving the control interface of the convolution address FSM (`Fsmv`). It accepts image words from an upstream ready/valid source and replays them as the FSM's load protocol: `load` held high, with single-cycle `valid` strobes separated by at least one idle cycle. It then issues the start-of-processing pulse and waits for end-of-processing. It sits between the processor/GPIO bridge and `Fsmv`.

---
 rtl/fsmv_pkg.sv | 34 +++
 rtl/fsmv_drv_timer.sv | 37 +++
 rtl/fsmv_driver.sv | 187 ++++++++++++++++++
 tb/tb_fsmv_driver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsmv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fsmv_pkg                                           |
// | Description : Shared constants for the Fsmv address FSM and its  |
// |               host-side driver: default widths, driver state     |
// |               encoding and a timer-width helper.                 |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package fsmv_pkg;

  // Default widths shared with Fsmv
  localparam int FSMV_NB_IMAGE = 10;
  localparam int FSMV_NB_DATA  = 8;

  // Driver state encoding
  localparam int              ST_W      = 3;
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD   = 3'd1;
  localparam logic [ST_W-1:0] ST_GAP    = 3'd2;
  localparam logic [ST_W-1:0] ST_SETTLE = 3'd3;
  localparam logic [ST_W-1:0] ST_SOP    = 3'd4;
  localparam logic [ST_W-1:0] ST_RUN    = 3'd5;

  // Width needed by a down-counter that must hold the largest of three counts
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsmv_drv_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fsmv_drv_timer                                     |
// | Description : Loadable down-counter with zero flag. Used by the  |
// |               driver for settle, SoP-width and watchdog counts.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module fsmv_drv_timer
  import fsmv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_CLK,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Load has priority; decrement saturates at zero so the flag stays valid
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fsmv_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fsmv_driver                                        |
// | Description : Host-side sequencer for the Fsmv control interface.|
// |               Replays upstream ready/valid words as the Fsmv     |
// |               load protocol, then pulses SoP and waits for EoP.  |
// |               Optional RUN watchdog: define FSMV_DRV_TIMEOUT_EN. |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module fsmv_driver
  import fsmv_pkg::*;
#(
  parameter int NB_IMAGE      = FSMV_NB_IMAGE,
  parameter int NB_DATA       = FSMV_NB_DATA,
  parameter int SETTLE_CYCLES = 6,
  parameter int SOP_CYCLES    = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic                i_CLK,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_IMAGE-1:0] i_imgLength,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic                i_dataVld,
  output logic                o_dataRdy,
  output logic [NB_DATA-1:0]  o_data,
  output logic                o_valid,
  output logic                o_load,
  output logic [NB_IMAGE-1:0] o_imgLength,
  output logic                o_SoP,
  input  logic                i_EoP,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error
);

  // One timer covers settle, SoP width and watchdog, so size it for the largest
  localparam int TW = tmr_width(SETTLE_CYCLES, SOP_CYCLES, TIMEOUT);
  // Word counter is one bit wider than the length so length = all-ones cannot wrap
  localparam int CW = NB_IMAGE + 1;

  logic [ST_W-1:0]     r_state;
  logic [ST_W-1:0]     w_state_nxt;
  logic [NB_IMAGE-1:0] r_len;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_last;
  logic [NB_DATA-1:0]  r_data;
  logic                r_done;
  logic                w_start_acc;
  logic                w_word_acc;
  logic                w_tmr_load;
  logic [TW-1:0]       w_tmr_value;
  logic                w_tmr_dec;
  logic                w_tmr_zero;

  assign w_start_acc = (r_state == ST_IDLE) && i_start;
  assign w_word_acc  = (r_state == ST_LOAD) && i_dataVld;
  assign w_last      = {1'b0, r_len} + CW'(1);

  // State register
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the timer is (re)loaded on entry to each timed state
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_value = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (i_dataVld) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (r_cnt == w_last) begin
          // SETTLE lasts SETTLE_CYCLES+1 cycles: the load-fall cycle plus the idle gap
          w_state_nxt = ST_SETTLE;
          w_tmr_load  = 1'b1;
          w_tmr_value = TW'(SETTLE_CYCLES);
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_SETTLE: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_SOP;
          w_tmr_load  = 1'b1;
          w_tmr_value = TW'(SOP_CYCLES - 1);
        end
      end
      ST_SOP: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_RUN;
`ifdef FSMV_DRV_TIMEOUT_EN
          w_tmr_load  = 1'b1;
          w_tmr_value = TW'(TIMEOUT - 1);
`endif
        end
      end
      ST_RUN: begin
        if (i_EoP) begin
          w_state_nxt = ST_IDLE;
        end
`ifdef FSMV_DRV_TIMEOUT_EN
        else if (w_tmr_zero) begin
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode straight from the state register
  always_comb begin
    o_dataRdy = (r_state == ST_LOAD);
    o_load    = (r_state == ST_LOAD) || (r_state == ST_GAP);
    o_valid   = (r_state == ST_GAP);
    o_SoP     = (r_state == ST_SOP);
    o_busy    = (r_state != ST_IDLE);
  end

  assign w_tmr_dec = (r_state == ST_SETTLE) || (r_state == ST_SOP) || (r_state == ST_RUN);

  fsmv_drv_timer #(
    .WIDTH (TW)
  ) u_timer (
    .i_CLK   (i_CLK),
    .i_reset (i_reset),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .i_dec   (w_tmr_dec),
    .o_zero  (w_tmr_zero)
  );

  // Frame datapath: length latch, word counter, data register, done pulse
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_RUN) && i_EoP;
      if (w_start_acc) begin
        r_len <= i_imgLength;
        r_cnt <= '0;
      end
      if (w_word_acc) begin
        r_data <= i_data;
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign o_data      = r_data;
  assign o_imgLength = r_len;
  assign o_done      = r_done;

`ifdef FSMV_DRV_TIMEOUT_EN
  logic r_error;

  // Sticky watchdog flag, cleared only when a new frame starts
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      r_error <= 1'b0;
    end else if (w_start_acc) begin
      r_error <= 1'b0;
    end else if ((r_state == ST_RUN) && !i_EoP && w_tmr_zero) begin
      r_error <= 1'b1;
    end
  end

  assign o_error = r_error;
`else
  assign o_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsmv_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_fsmv_driver                                     |
// | Description : Self-checking bench for fsmv_driver. Random data   |
// |               and stalls; expected words, counts and timing are  |
// |               derived from the frame rules (FSMV_DRV_TIMEOUT_EN  |
// |               selects the watchdog scenario).                    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_fsmv_driver;

  localparam int NB_IMAGE      = 10;
  localparam int NB_DATA       = 8;
  localparam int SETTLE_CYCLES = 6;
  localparam int SOP_CYCLES    = 4;
  localparam int TIMEOUT       = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [NB_IMAGE-1:0] img_len = '0;
  logic [NB_DATA-1:0]  din = '0;
  logic                din_vld = 1'b0;
  logic                eop = 1'b0;
  logic                o_dataRdy, o_valid, o_load, o_SoP, o_busy, o_done, o_error;
  logic [NB_DATA-1:0]  o_data;
  logic [NB_IMAGE-1:0] o_imgLength;

  int total = 0;
  int bad   = 0;
  logic [NB_DATA-1:0] exp_q[$];

  always #5 clk = ~clk;

  fsmv_driver #(
    .NB_IMAGE      (NB_IMAGE),
    .NB_DATA       (NB_DATA),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SOP_CYCLES    (SOP_CYCLES),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .i_CLK       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_imgLength (img_len),
    .i_data      (din),
    .i_dataVld   (din_vld),
    .o_dataRdy   (o_dataRdy),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_load      (o_load),
    .o_imgLength (o_imgLength),
    .o_SoP       (o_SoP),
    .i_EoP       (eop),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},  o_dataRdy,   0);
    chk({tag, "_data"}, o_data,      0);
    chk({tag, "_vld"},  o_valid,     0);
    chk({tag, "_load"}, o_load,      0);
    chk({tag, "_len"},  o_imgLength, 0);
    chk({tag, "_sop"},  o_SoP,       0);
    chk({tag, "_busy"}, o_busy,      0);
    chk({tag, "_done"}, o_done,      0);
    chk({tag, "_err"},  o_error,     0);
  endtask

  // Load phase: every accepted word must come back as a strobe exactly one cycle later
  task automatic load_phase(input int len, input int vld_pct, input bit noise, output bit ok);
    int strobes = 0;
    int guard   = 0;
    bit acc_prev = 1'b0;
    ok = 1'b0;
    forever begin
      chk("strobe_latency", o_valid, acc_prev);
      if (o_valid) begin
        chk("strobe_in_load", o_load, 1);
        if (exp_q.size() == 0) chk("strobe_no_word", 1, 0);
        else chk("data_order", o_data, exp_q.pop_front());
        strobes++;
      end
      if (acc_prev) chk("rdy_after_accept", o_dataRdy, 0);
      chk("len_held", o_imgLength, len);
      if (strobes == len + 1) begin
        ok = 1'b1;
        break;
      end
      if (guard > 40 * (len + 1) + 100) begin
        chk("load_timeout", strobes, len + 1);
        break;
      end
      din_vld = ($urandom_range(99) < vld_pct);
      din     = NB_DATA'($urandom);
      if (noise) begin
        start   = ($urandom_range(3) == 0);
        eop     = ($urandom_range(3) == 0);
        img_len = NB_IMAGE'($urandom);
      end
      acc_prev = o_dataRdy && din_vld;
      if (acc_prev) exp_q.push_back(din);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    eop   = 1'b0;
  endtask

  // One frame from IDLE; returns in the first RUN cycle when eop_dly < 0,
  // otherwise in the cycle where o_done is expected high.
  task automatic run_frame(input int len, input int vld_pct, input bit noise, input int eop_dly);
    bit ok;
    exp_q.delete();
    chk("idle_busy", o_busy, 0);
    start   = 1'b1;
    img_len = NB_IMAGE'(len);
    @(negedge clk);
    start = 1'b0;
    chk("len_latch", o_imgLength, len);
    chk("load_hi", o_load, 1);
    chk("busy_hi", o_busy, 1);
    chk("err_clear", o_error, 0);
    chk("done_lo", o_done, 0);
    load_phase(len, vld_pct, noise, ok);
    if (!ok) return;
    // Words offered after the frame is full must be ignored
    din_vld = 1'b1;
    @(negedge clk);
    chk("load_fall", o_load, 0);
    for (int k = 0; k <= SETTLE_CYCLES + SOP_CYCLES + 1; k++) begin
      if (k > 0) @(negedge clk);
      chk("sop_window", o_SoP, (k >= SETTLE_CYCLES + 1 && k <= SETTLE_CYCLES + SOP_CYCLES) ? 1 : 0);
      chk("no_strobe_post", o_valid, 0);
      chk("no_rdy_post", o_dataRdy, 0);
      chk("busy_post", o_busy, 1);
    end
    din_vld = 1'b0;
    if (eop_dly < 0) return;
    repeat (eop_dly) begin
      chk("run_busy", o_busy, 1);
      chk("run_no_done", o_done, 0);
      @(negedge clk);
    end
    eop = 1'b1;
    @(negedge clk);
    eop = 1'b0;
    chk("done_pulse", o_done, 1);
    chk("busy_fall", o_busy, 0);
    chk("done_no_err", o_error, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: observed=stuck expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Nominal, single word back-to-back, stalls, noise, maximum length
    run_frame(15, 100, 1'b0, 3);
    run_frame(0, 100, 1'b0, 0);
    @(negedge clk);
    chk("done_one_cycle", o_done, 0);
    run_frame(15, 40, 1'b0, 5);
    run_frame(15, 70, 1'b1, 2);
    run_frame((1 << NB_IMAGE) - 1, 90, 1'b0, 1);

    // Reset after the fifth word: everything clears, then a clean full frame
    @(negedge clk);
    start   = 1'b1;
    img_len = NB_IMAGE'(15);
    @(negedge clk);
    start   = 1'b0;
    din_vld = 1'b1;
    n = 0;
    for (int g = 0; g < 40 && n < 5; g++) begin
      din = NB_DATA'($urandom);
      @(negedge clk);
      if (o_valid) n++;
    end
    chk("pre_reset_words", n, 5);
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst     = 1'b0;
    din_vld = 1'b0;
    @(negedge clk);
    chk("no_done_after_reset", o_done, 0);
    run_frame(15, 100, 1'b0, 1);

    // RUN with no EoP
    run_frame(2, 100, 1'b0, -1);
`ifdef FSMV_DRV_TIMEOUT_EN
    for (int k = 1; k <= TIMEOUT; k++) begin
      chk("wd_busy", o_busy, 1);
      chk("wd_err_lo", o_error, 0);
      chk("wd_done_lo", o_done, 0);
      @(negedge clk);
    end
    chk("wd_idle", o_busy, 0);
    chk("wd_err_hi", o_error, 1);
    chk("wd_no_done", o_done, 0);
    @(negedge clk);
    chk("wd_err_sticky", o_error, 1);
    chk("wd_still_no_done", o_done, 0);
`else
    for (int k = 1; k <= 2 * TIMEOUT; k++) begin
      chk("wait_busy", o_busy, 1);
      chk("wait_err_lo", o_error, 0);
      chk("wait_done_lo", o_done, 0);
      @(negedge clk);
    end
    eop = 1'b1;
    @(negedge clk);
    eop = 1'b0;
    chk("late_done", o_done, 1);
    chk("late_busy_fall", o_busy, 0);
`endif
    run_frame(3, 80, 1'b0, 2);
    @(negedge clk);
    chk("final_done_lo", o_done, 0);
    chk("final_idle", o_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
